// File: rtl/ent_enc_input_scheduler_if.sv
// Stream-side and encoder-side signal bundle for ent_enc_input_scheduler.
// The scheduler takes the slave view; the source/encoder side takes the master view.
interface ent_enc_input_scheduler_if #(
    parameter int unsigned RANGE_WIDTH  = 16,
    parameter int unsigned SYMBOL_WIDTH = 4,
    parameter int unsigned BOOL_LANES   = 3
);
    logic                               in_valid;
    logic                               in_ready;
    logic                               in_bool;
    logic [RANGE_WIDTH-1:0]             in_fl;
    logic [RANGE_WIDTH-1:0]             in_fh;
    logic [SYMBOL_WIDTH-1:0]            in_symbol;
    logic [SYMBOL_WIDTH:0]              in_nsyms;
    logic                               in_last;
    logic                               enc_flag_last;
    logic                               enc_reset;
    logic                               enc_valid;
    logic                               enc_flag_first;
    logic                               enc_final_flag;
    logic [RANGE_WIDTH-1:0]             enc_fl;
    logic [RANGE_WIDTH-1:0]             enc_fh;
    logic [SYMBOL_WIDTH:0]              enc_nsyms;
    logic [BOOL_LANES-1:0]              enc_bool;
    logic [BOOL_LANES*SYMBOL_WIDTH-1:0] enc_symbol;
    logic                               err_timeout;

    modport master (
        output in_valid, in_bool, in_fl, in_fh, in_symbol, in_nsyms, in_last, enc_flag_last,
        input  in_ready, enc_reset, enc_valid, enc_flag_first, enc_final_flag,
               enc_fl, enc_fh, enc_nsyms, enc_bool, enc_symbol, err_timeout
    );

    modport slave (
        input  in_valid, in_bool, in_fl, in_fh, in_symbol, in_nsyms, in_last, enc_flag_last,
        output in_ready, enc_reset, enc_valid, enc_flag_first, enc_final_flag,
               enc_fl, enc_fh, enc_nsyms, enc_bool, enc_symbol, err_timeout
    );
endinterface

// File: rtl/ent_enc_input_scheduler.sv
// Packs boolean symbol runs into parallel encoder lanes, issues CDF symbols alone,
// and sequences the end of a frame (final flag, wait for last, encoder reset).
module ent_enc_input_scheduler #(
    parameter int unsigned RANGE_WIDTH   = 16,
    parameter int unsigned SYMBOL_WIDTH  = 4,
    parameter int unsigned BOOL_LANES    = 3,
    parameter int unsigned FLUSH_TIMEOUT = 4096
) (
    input  logic                      top_clk,
    input  logic                      top_reset,
    ent_enc_input_scheduler_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(BOOL_LANES + 1);
    localparam int unsigned TMR_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam int unsigned NS_W  = SYMBOL_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BOOL_LANES);
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_PACK  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RST   = 2'd2
    } state_t;

    typedef logic [BOOL_LANES-1:0][SYMBOL_WIDTH-1:0] lanes_t;

    // Pending bundle B and sequencing state
    state_t                  r_state,         w_state;
    logic [CNT_W-1:0]        r_cnt,           w_cnt;
    logic                    r_cdf,           w_cdf;
    logic                    r_last,          w_last;
    logic                    r_first_pending, w_first_pending;
    lanes_t                  r_lane,          w_lane;
    logic [RANGE_WIDTH-1:0]  r_b_fl,          w_b_fl;
    logic [RANGE_WIDTH-1:0]  r_b_fh,          w_b_fh;
    logic [NS_W-1:0]         r_b_nsyms,       w_b_nsyms;
    logic [TMR_W-1:0]        r_timer,         w_timer;

    // Registered outputs
    logic                    r_in_ready,       w_in_ready;
    logic                    r_enc_valid,      w_enc_valid;
    logic                    r_enc_flag_first, w_enc_flag_first;
    logic                    r_enc_final_flag, w_enc_final_flag;
    logic                    r_err_timeout,    w_err_timeout;
    logic [BOOL_LANES-1:0]   r_enc_bool,       w_enc_bool;
    lanes_t                  r_enc_symbol,     w_enc_symbol;
    logic [RANGE_WIDTH-1:0]  r_enc_fl,         w_enc_fl;
    logic [RANGE_WIDTH-1:0]  r_enc_fh,         w_enc_fh;
    logic [NS_W-1:0]         r_enc_nsyms,      w_enc_nsyms;

    logic w_accept;
    logic w_emit;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_emit   = (r_state == ST_PACK) && (r_cnt != '0) &&
                      (r_cdf || (r_cnt == CNT_FULL) || !bus.in_valid ||
                       (w_accept && bus.in_bool) || r_last);

    // Next-state, bundle packing and output loading
    always_comb begin
        w_state          = r_state;
        w_cnt            = r_cnt;
        w_cdf            = r_cdf;
        w_last           = r_last;
        w_first_pending  = r_first_pending;
        w_lane           = r_lane;
        w_b_fl           = r_b_fl;
        w_b_fh           = r_b_fh;
        w_b_nsyms        = r_b_nsyms;
        w_timer          = r_timer;
        w_enc_valid      = 1'b0;
        w_enc_flag_first = r_enc_flag_first;
        w_err_timeout    = r_err_timeout;
        w_enc_bool       = r_enc_bool;
        w_enc_symbol     = r_enc_symbol;
        w_enc_fl         = r_enc_fl;
        w_enc_fh         = r_enc_fh;
        w_enc_nsyms      = r_enc_nsyms;

        unique case (r_state)
            ST_PACK: begin
                if (w_emit) begin
                    w_enc_valid      = 1'b1;
                    w_enc_flag_first = r_first_pending;
                    w_first_pending  = 1'b0;
                    for (int unsigned i = 0; i < BOOL_LANES; i++) begin
                        if (CNT_W'(i) < r_cnt) begin
                            w_enc_bool[i]   = (i == 0) && r_cdf;
                            w_enc_symbol[i] = r_lane[i];
                        end else begin
                            w_enc_bool[i]   = 1'b1;
                            w_enc_symbol[i] = '0;
                        end
                    end
                    w_enc_fl    = r_cdf ? r_b_fl    : '0;
                    w_enc_fh    = r_cdf ? r_b_fh    : '0;
                    w_enc_nsyms = r_cdf ? r_b_nsyms : '0;
                    w_cnt       = '0;
                    w_cdf       = 1'b0;
                    w_last      = 1'b0;
                    if (r_last) begin
                        w_state = ST_FLUSH;
                        w_timer = '0;
                    end
                end
                // CDF always starts a fresh bundle; booleans append unless B was just emitted
                if (w_accept) begin
                    w_last = bus.in_last;
                    if (bus.in_bool) begin
                        w_lane    = '0;
                        w_lane[0] = bus.in_symbol;
                        w_cnt     = CNT_W'(1);
                        w_cdf     = 1'b1;
                        w_b_fl    = bus.in_fl;
                        w_b_fh    = bus.in_fh;
                        w_b_nsyms = bus.in_nsyms;
                    end else if (w_emit || (r_cnt == '0)) begin
                        w_lane    = '0;
                        w_lane[0] = SYMBOL_WIDTH'(bus.in_symbol[0]);
                        w_cnt     = CNT_W'(1);
                        w_cdf     = 1'b0;
                    end else begin
                        for (int unsigned i = 0; i < BOOL_LANES; i++) begin
                            if (CNT_W'(i) == r_cnt) begin
                                w_lane[i] = SYMBOL_WIDTH'(bus.in_symbol[0]);
                            end
                        end
                        w_cnt = r_cnt + CNT_W'(1);
                        w_cdf = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.enc_flag_last) begin
                    w_state = ST_RST;
                end else if (r_timer == TMR_END) begin
                    w_err_timeout = 1'b1;
                    w_state       = ST_RST;
                end else begin
                    w_timer = r_timer + TMR_W'(1);
                end
            end
            ST_RST: begin
                w_first_pending = 1'b1;
                w_state         = ST_PACK;
            end
            default: begin
                w_state = ST_PACK;
            end
        endcase

        w_enc_final_flag = (w_state == ST_FLUSH);
        w_in_ready       = (w_state == ST_PACK) && !w_last;
    end

    always_ff @(posedge top_clk) begin
        if (top_reset) begin
            r_state          <= ST_PACK;
            r_cnt            <= '0;
            r_cdf            <= 1'b0;
            r_last           <= 1'b0;
            r_first_pending  <= 1'b1;
            r_lane           <= '0;
            r_b_fl           <= '0;
            r_b_fh           <= '0;
            r_b_nsyms        <= '0;
            r_timer          <= '0;
            r_in_ready       <= 1'b0;
            r_enc_valid      <= 1'b0;
            r_enc_flag_first <= 1'b0;
            r_enc_final_flag <= 1'b0;
            r_err_timeout    <= 1'b0;
            r_enc_bool       <= '1;
            r_enc_symbol     <= '0;
            r_enc_fl         <= '0;
            r_enc_fh         <= '0;
            r_enc_nsyms      <= '0;
        end else begin
            r_state          <= w_state;
            r_cnt            <= w_cnt;
            r_cdf            <= w_cdf;
            r_last           <= w_last;
            r_first_pending  <= w_first_pending;
            r_lane           <= w_lane;
            r_b_fl           <= w_b_fl;
            r_b_fh           <= w_b_fh;
            r_b_nsyms        <= w_b_nsyms;
            r_timer          <= w_timer;
            r_in_ready       <= w_in_ready;
            r_enc_valid      <= w_enc_valid;
            r_enc_flag_first <= w_enc_flag_first;
            r_enc_final_flag <= w_enc_final_flag;
            r_err_timeout    <= w_err_timeout;
            r_enc_bool       <= w_enc_bool;
            r_enc_symbol     <= w_enc_symbol;
            r_enc_fl         <= w_enc_fl;
            r_enc_fh         <= w_enc_fh;
            r_enc_nsyms      <= w_enc_nsyms;
        end
    end

    // Encoder reset follows the block reset immediately as well as the RST state
    assign bus.enc_reset      = top_reset | (r_state == ST_RST);
    assign bus.in_ready       = r_in_ready;
    assign bus.enc_valid      = r_enc_valid;
    assign bus.enc_flag_first = r_enc_flag_first;
    assign bus.enc_final_flag = r_enc_final_flag;
    assign bus.err_timeout    = r_err_timeout;
    assign bus.enc_bool       = r_enc_bool;
    assign bus.enc_symbol     = r_enc_symbol;
    assign bus.enc_fl         = r_enc_fl;
    assign bus.enc_fh         = r_enc_fh;
    assign bus.enc_nsyms      = r_enc_nsyms;
endmodule
